// File: rtl/uart_dbus_bridge.sv
// UART host bridge: byte frames from the host become word accesses on the dBus, and ack/data bytes go back.
// Optional frame/response timeout is built only when UART_DBUS_BRIDGE_TIMEOUT_EN is defined.
module uart_dbus_bridge #(
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_rdy,
  output logic        tx_vld,
  output logic [7:0]  tx_data,
  output logic        bus_cmd_valid,
  input  logic        bus_cmd_ready,
  output logic        bus_cmd_wr,
  output logic [31:0] bus_cmd_address,
  output logic [31:0] bus_cmd_data,
  output logic [1:0]  bus_cmd_size,
  input  logic        bus_rsp_ready,
  input  logic        bus_rsp_error,
  input  logic [31:0] bus_rsp_data,
  output logic        cpu_hold,
  output logic        overrun
);
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, OP_G = 8'h47, OP_H = 8'h48;
  localparam logic [7:0] ACK = 8'h06, NAK = 8'h15;
  localparam logic [63:0] TO_CYCLES =
    64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUD_RATE);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, CMD, RSP, TX} state_t;

  state_t      state, state_next, op_next;
  logic [1:0]  cnt;
  logic [31:0] addr_sr, data_sr;
  logic [39:0] reply;
  logic [2:0]  tx_left;
  logic        tx_wait, tx_fire, tx_last, take_op, timeout;

  // Bus cmd: valid/address/data/wr hold steady while valid=1 and ready=0; the command
  // is taken on the edge where valid and ready are both 1, and valid drops right after.
  assign bus_cmd_address = {addr_sr[31:2], 2'b00};
  assign bus_cmd_data    = data_sr;
  assign bus_cmd_size    = 2'b10;

  // tx_wait skips one cycle after each pulse so tx_rdy is never re-sampled too early.
  assign tx_fire = (state == TX) && tx_rdy && !tx_wait;
  assign tx_last = tx_fire && (tx_left == 3'd1);
  // A byte arriving as TX hands back to IDLE is treated as the next opcode.
  assign take_op = rx_valid && ((state == IDLE) || tx_last);

`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 64'd1);
  logic [TO_W-1:0] to_cnt;
  logic            to_run;

  assign to_run  = ((state == ADDR) || (state == DATA) || (state == RSP)) && !rx_valid;
  assign timeout = to_run && (to_cnt == TO_W'(TO_CYCLES - 64'd1));

  always_ff @(posedge clk) begin
    if (reset || !to_run) to_cnt <= '0;
    else if (!timeout)    to_cnt <= to_cnt + TO_W'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TO_CYCLES == 64'd0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    bus_cmd_valid = 1'b0;
    op_next       = TX;
    if ((rx_data == OP_W) || (rx_data == OP_R)) op_next = ADDR;
    case (state)
      IDLE: if (rx_valid) state_next = op_next;
      ADDR: begin
        if (rx_valid) begin
          if (cnt == 2'd3) state_next = bus_cmd_wr ? DATA : CMD;
        end else if (timeout) state_next = IDLE;
      end
      DATA: begin
        if (rx_valid) begin
          if (cnt == 2'd3) state_next = CMD;
        end else if (timeout) state_next = IDLE;
      end
      CMD: begin
        bus_cmd_valid = 1'b1;
        if (bus_cmd_ready) state_next = bus_cmd_wr ? TX : RSP;
      end
      RSP: if (bus_rsp_ready || timeout) state_next = TX;
      TX: if (tx_last) state_next = rx_valid ? op_next : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      addr_sr    <= 32'h0;
      data_sr    <= 32'h0;
      bus_cmd_wr <= 1'b0;
      reply      <= 40'h0;
      tx_left    <= 3'd0;
      tx_wait    <= 1'b0;
      tx_vld     <= 1'b0;
      tx_data    <= 8'h00;
      cpu_hold   <= HOLD_AT_RESET;
      overrun    <= 1'b0;
    end else begin
      state   <= state_next;
      tx_vld  <= tx_fire;
      tx_wait <= tx_fire;
      case (state)
        ADDR: if (rx_valid) begin
          addr_sr <= {rx_data, addr_sr[31:8]};
          cnt     <= cnt + 2'd1;
        end
        DATA: if (rx_valid) begin
          data_sr <= {rx_data, data_sr[31:8]};
          cnt     <= cnt + 2'd1;
        end
        CMD: if (bus_cmd_ready && bus_cmd_wr) begin
          reply   <= {32'h0, ACK};
          tx_left <= 3'd1;
        end
        RSP: begin
          if (bus_rsp_ready) begin
            reply   <= bus_rsp_error ? {32'h0, NAK} : {bus_rsp_data, ACK};
            tx_left <= bus_rsp_error ? 3'd1 : 3'd5;
          end else if (timeout) begin
            reply   <= {32'h0, NAK};
            tx_left <= 3'd1;
          end
        end
        default: ;
      endcase
      if (tx_fire) begin
        tx_data <= reply[7:0];
        reply   <= {8'h00, reply[39:8]};
        tx_left <= tx_left - 3'd1;
      end
      if (rx_valid && !take_op && ((state == CMD) || (state == RSP) || (state == TX)))
        overrun <= 1'b1;
      if (take_op) begin
        cnt <= 2'd0;
        case (rx_data)
          OP_W: bus_cmd_wr <= 1'b1;
          OP_R: bus_cmd_wr <= 1'b0;
          OP_G: begin
            cpu_hold <= 1'b0;
            reply    <= {32'h0, ACK};
            tx_left  <= 3'd1;
          end
          OP_H: begin
            cpu_hold <= 1'b1;
            reply    <= {32'h0, ACK};
            tx_left  <= 3'd1;
          end
          default: begin
            reply   <= {32'h0, NAK};
            tx_left <= 3'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Self-checking bench for uart_dbus_bridge: TX bytes and bus commands are checked against expected queues.
module tb_uart_dbus_bridge;
  localparam int CLK_FREQ  = 1152000;
  localparam int BAUD_RATE = 115200;
  localparam int TO_CYCLES = 4 * 10 * CLK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        reset, rx_valid, tx_rdy, tx_vld;
  logic [7:0]  rx_data, tx_data;
  logic        bus_cmd_valid, bus_cmd_ready, bus_cmd_wr;
  logic [31:0] bus_cmd_address, bus_cmd_data, bus_rsp_data;
  logic [1:0]  bus_cmd_size;
  logic        bus_rsp_ready, bus_rsp_error, cpu_hold, overrun;

  logic [7:0]  exp_q[$];
  logic [64:0] exp_cmd_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0, n_fail = 0, stall_n = 0, tx_count = 0, cmd_count = 0;
  bit          rsp_err = 1'b0;
  logic        tx_vld_prev = 1'b0;
  logic [7:0]  tx_exp;

  uart_dbus_bridge #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .TIMEOUT_BYTES(4), .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_data(tx_data),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready), .bus_cmd_wr(bus_cmd_wr),
    .bus_cmd_address(bus_cmd_address), .bus_cmd_data(bus_cmd_data), .bus_cmd_size(bus_cmd_size),
    .bus_rsp_ready(bus_rsp_ready), .bus_rsp_error(bus_rsp_error), .bus_rsp_data(bus_rsp_data),
    .cpu_hold(cpu_hold), .overrun(overrun)
  );

  // Clock
  always #5 clk = ~clk;

  // TX scoreboard
  always @(negedge clk) begin
    if (tx_vld === 1'b1) begin
      tx_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_extra: got byte %02h, expected no byte", tx_data);
      end else begin
        tx_exp = exp_q.pop_front();
        if (tx_data !== tx_exp) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, tx_exp);
        end
      end
      n_checks++;
      if (tx_vld_prev !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_pulse_width: tx_vld high %0d cycles in a row, expected 1", 2);
      end
    end
    tx_vld_prev = tx_vld;
  end

  // UART transmitter model: busy for a random time after each accepted byte
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_vld === 1'b1) begin
        n_checks++;
        if (tx_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL tx_rdy_gate: pulse issued with tx_rdy=%b, expected 1", tx_rdy);
        end
        tx_rdy = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_rdy = 1'b1;
      end
    end
  end

  // Bus slave model with command scoreboard, stall injection and word memory
  initial begin
    logic [64:0] cap, e;
    bus_cmd_ready = 1'b0; bus_rsp_ready = 1'b0; bus_rsp_error = 1'b0; bus_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      bus_rsp_ready = 1'b0;
      bus_rsp_error = 1'b0;
      if (bus_cmd_valid === 1'b1) begin
        cmd_count++;
        cap = {bus_cmd_wr, bus_cmd_address, bus_cmd_data};
        n_checks++;
        if (bus_cmd_size !== 2'b10) begin
          n_fail++;
          $display("FAIL cmd_size: got %b, expected 10", bus_cmd_size);
        end
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_extra: got wr=%b addr=%08h, expected no command", cap[64], cap[63:32]);
        end else begin
          e = exp_cmd_q.pop_front();
          if (cap[64:32] !== e[64:32] || (e[64] && cap[31:0] !== e[31:0])) begin
            n_fail++;
            $display("FAIL cmd_payload: got wr=%b addr=%08h data=%08h, expected wr=%b addr=%08h data=%08h",
                     cap[64], cap[63:32], cap[31:0], e[64], e[63:32], e[31:0]);
          end
        end
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          n_checks++;
          if (bus_cmd_valid !== 1'b1 || {bus_cmd_wr, bus_cmd_address, bus_cmd_data} !== cap ||
              bus_cmd_size !== 2'b10) begin
            n_fail++;
            $display("FAIL cmd_stall_stable: got valid=%b addr=%08h data=%08h, expected valid=1 addr=%08h data=%08h",
                     bus_cmd_valid, bus_cmd_address, bus_cmd_data, cap[63:32], cap[31:0]);
          end
        end
        bus_cmd_ready = 1'b1;
        @(negedge clk);
        bus_cmd_ready = 1'b0;
        n_checks++;
        if (bus_cmd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL cmd_valid_drop: got %b after acceptance, expected 0", bus_cmd_valid);
        end
        if (cap[64]) mem[cap[63:32]] = cap[31:0];
        else begin
          bus_rsp_ready = 1'b1;
          bus_rsp_error = rsp_err;
          bus_rsp_data  = mem.exists(cap[63:32]) ? mem[cap[63:32]] : 32'h0;
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, 2));
  endtask

  task automatic frame_write(input logic [31:0] a, input logic [31:0] d);
    exp_cmd_q.push_back({1'b1, a & 32'hFFFF_FFFC, d});
    exp_q.push_back(8'h06);
    send_byte(8'h57, 0);
    send_word(a);
    send_word(d);
  endtask

  task automatic frame_read(input logic [31:0] a, input logic [31:0] d, input bit err);
    exp_cmd_q.push_back({1'b0, a & 32'hFFFF_FFFC, 32'h0});
    if (err) exp_q.push_back(8'h15);
    else begin
      exp_q.push_back(8'h06);
      for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    end
    send_byte(8'h52, 0);
    send_word(a);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || exp_cmd_q.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes and %0d commands still pending, expected 0",
               exp_q.size(), exp_cmd_q.size());
      exp_q.delete();
      exp_cmd_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b, expected 1", cpu_hold); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    n_checks++;
    if (tx_vld !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx: got vld=%b data=%02h, expected 0/00", tx_vld, tx_data);
    end
    n_checks++;
    if (bus_cmd_valid !== 1'b0 || bus_cmd_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ctl: got valid=%b wr=%b, expected 0/0", bus_cmd_valid, bus_cmd_wr);
    end
    n_checks++;
    if (bus_cmd_address !== 32'h0 || bus_cmd_data !== 32'h0 || bus_cmd_size !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_cmd_payload: got addr=%08h data=%08h size=%b, expected 0/0/10",
               bus_cmd_address, bus_cmd_data, bus_cmd_size);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (tx_count !== 0) begin n_fail++; $display("FAIL reset_quiet: got %0d tx pulses, expected 0", tx_count); end
  endtask

  task automatic test_write();
    frame_write(32'h0000_0100, 32'hDEAD_BEEF);
    n_checks++;
    if (bus_cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL write_latency: bus_cmd_valid=%b one cycle after last byte, expected 1", bus_cmd_valid);
    end
    wait_drain();
  endtask

  task automatic test_read_stall();
    stall_n = 5;
    frame_read(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    n_checks++;
    if (bus_cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL read_latency: bus_cmd_valid=%b one cycle after last byte, expected 1", bus_cmd_valid);
    end
    wait_drain();
    stall_n = 0;
  endtask

  task automatic test_read_error();
    rsp_err = 1'b1;
    frame_read(32'h0010_0000, 32'h0, 1'b1);
    wait_drain();
    rsp_err = 1'b0;
  endtask

  task automatic test_bad_opcode();
    exp_q.push_back(8'h15);
    send_byte(8'h99, 0);
    wait_drain();
    frame_read(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    wait_drain();
  endtask

  task automatic test_hold();
    exp_q.push_back(8'h06);
    send_byte(8'h47, 0);
    wait_drain();
    n_checks++;
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL hold_go: got cpu_hold=%b, expected 0", cpu_hold); end
    exp_q.push_back(8'h06);
    send_byte(8'h48, 0);
    wait_drain();
    n_checks++;
    if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hold_halt: got cpu_hold=%b, expected 1", cpu_hold); end
  endtask

  task automatic test_overrun();
    int k = 0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b, expected 0", overrun); end
    frame_read(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    while (tx_vld !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) begin n_fail++; $display("FAIL overrun_tx_wait: no reply within %0d cycles, expected one", k); end
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
    wait_drain();
    exp_q.push_back(8'h06);
    send_byte(8'h48, 0);
    wait_drain();
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[4], d[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = ((i + 1) << 12) | $urandom_range(0, 255);
      d[i] = $urandom;
      frame_write(a[i], d[i]);
      wait_drain();
    end
    for (int i = 3; i >= 0; i--) begin
      frame_read(a[i], d[i], 1'b0);
      wait_drain();
    end
  endtask

`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int c0, t0;
    c0 = cmd_count;
    t0 = tx_count;
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (TO_CYCLES + 50) @(negedge clk);
    n_checks++;
    if (cmd_count !== c0) begin n_fail++; $display("FAIL timeout_no_cmd: got %0d commands, expected %0d", cmd_count, c0); end
    n_checks++;
    if (tx_count !== t0) begin n_fail++; $display("FAIL timeout_no_tx: got %0d bytes, expected %0d", tx_count, t0); end
    exp_q.push_back(8'h06);
    send_byte(8'h47, 0);
    wait_drain();
    n_checks++;
    if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL timeout_recover: got cpu_hold=%b, expected 0", cpu_hold); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_read_error();
    test_bad_opcode();
    test_hold();
    test_overrun();
    test_back_to_back();
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
